// File: rtl/mux_n_rr.sv
// N-channel, W-bit multiplexer with a registered output stage, per-channel
// valid/ready handshakes and a fixed-select or round-robin grant.
module mux_n_rr #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int CNT_W = 16,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   beat_cnt
);

  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W:0]   sel_ext;
  logic             fix_vld;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] scan_idx;
  int               scan_pos;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [W-1:0]     grant_data;
  logic             space;
  logic             xfer;
  logic             consume;

  // sel is widened so the range check stays meaningful when N is not a power of two
  assign sel_ext = {1'b0, sel};
  assign fix_vld = (sel_ext < (SEL_W+1)'(N)) && in_valid[sel];

  always_comb begin
    rr_vld   = 1'b0;
    rr_idx   = '0;
    scan_pos = 0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_pos = (int'(rr_ptr_q) + k) % N;
      scan_idx = SEL_W'(scan_pos);
      if (!rr_vld && in_valid[scan_idx]) begin
        rr_vld = 1'b1;
        rr_idx = scan_idx;
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end else if (fix_vld) begin
      grant_vld = 1'b1;
      grant_idx = sel;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*W +: W];
    end
  end

  assign space   = !out_valid_q || out_ready;
  assign xfer    = rst_n && grant_vld && space;
  assign consume = out_valid_q && out_ready;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  // A reload in the same cycle as a consume keeps out_valid high for full throughput
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    beat_cnt_d  = beat_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (consume) begin
      out_valid_d = 1'b0;
      beat_cnt_d  = beat_cnt_q + CNT_W'(1);
    end
    if (xfer) begin
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      rr_ptr_d    = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mux_n_rr.sv
// Bench for mux_n_rr: vector table for grants, scoreboard for delivered beats,
// hand sequences for backpressure, asynchronous reset and counter wrap.
module tb_mux_n_rr;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int SEL_W = 2;

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  logic [W+SEL_W-1:0] sb[$];

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  exp_rdy;
  } vec_t;

  vec_t tbl[15];

  mux_n_rr #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .beat_cnt(beat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted beat must match the oldest expected one
  always @(negedge clk) begin
    logic [W+SEL_W-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got beat %0h/%0d expected none", out_data, out_sel);
      end else begin
        e = sb.pop_front();
        chk("beat_data", 32'(out_data), 32'(e[W+SEL_W-1:SEL_W]));
        chk("beat_sel", 32'(out_sel), 32'(e[SEL_W-1:0]));
      end
    end
  end

  // Called at posedge+1; drives one cycle and returns at the next posedge+1
  task automatic vec_cycle(input logic m, input logic [1:0] s, input logic [3:0] v,
                           input logic ordy, input logic [31:0] d,
                           input logic [3:0] exp_rdy, input string name);
    int idx;
    logic [31:0] dd;
    mode = m; sel = s; in_valid = v; out_ready = ordy; in_data = d;
    @(negedge clk);
    chk(name, 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (exp_rdy[i]) idx = i;
      dd = d >> (idx * W);
      sb.push_back({dd[W-1:0], SEL_W'(idx)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 32'hD3A55A3C, 4'b0100};
    tbl[1]  = '{1'b0, 2'd1, 4'b0001, 1'b1, 32'h11223344, 4'b0000};
    tbl[2]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 32'h0F1E2D3C, 4'b0001};
    tbl[3]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 32'h96877869, 4'b1000};
    tbl[4]  = '{1'b0, 2'd1, 4'b0010, 1'b1, 32'hAABBCCDD, 4'b0010};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'h01234567, 4'b0100};
    tbl[6]  = '{1'b1, 2'd0, 4'b0011, 1'b1, 32'h89ABCDEF, 4'b0001};
    tbl[7]  = '{1'b1, 2'd2, 4'b0000, 1'b1, 32'hFEDCBA98, 4'b0000};
    tbl[8]  = '{1'b1, 2'd0, 4'b1100, 1'b1, 32'h5F6E7D8C, 4'b0100};
    tbl[9]  = '{1'b1, 2'd0, 4'b0110, 1'b1, 32'hC3B4A596, 4'b0010};
    tbl[10] = '{1'b0, 2'd3, 4'b0000, 1'b1, 32'h12345678, 4'b0000};
    tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 32'h9A000000, 4'b1000};
    tbl[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 32'h0000B100, 4'b0010};
    tbl[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 32'h3C00C200, 4'b1000};
    tbl[14] = '{1'b1, 2'd0, 4'b1010, 1'b1, 32'h4D00D300, 4'b0010};

    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = 32'hFFFFFFFF;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      vec_cycle(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].ordy, tbl[i].data,
                tbl[i].exp_rdy, $sformatf("vec%0d_in_ready", i));
    vec_cycle(1'b0, 2'd0, 4'b0000, 1'b1, 32'h0, 4'b0000, "drain_in_ready");
    chk("tbl_beat_cnt", 32'(beat_cnt), 32'd12);
    chk("tbl_out_valid", 32'(out_valid), 32'h0);

    // Backpressure: the held beat must survive three stalled cycles untouched
    vec_cycle(1'b0, 2'd0, 4'b0001, 1'b1, 32'h00000077, 4'b0001, "bp_load_in_ready");
    for (int s = 0; s < 3; s++) begin
      mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b0; in_data = 32'h11223344;
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_data", 32'(out_data), 32'h77);
      chk("bp_out_sel", 32'(out_sel), 32'h0);
      @(posedge clk);
      #1;
    end
    vec_cycle(1'b0, 2'd1, 4'b0000, 1'b1, 32'h0, 4'b0000, "bp_release_in_ready");
    chk("bp_beat_cnt", 32'(beat_cnt), 32'd13);
    chk("bp_out_valid_after", 32'(out_valid), 32'h0);

    // Asynchronous reset between edges while a beat is held
    vec_cycle(1'b0, 2'd3, 4'b1000, 1'b0, 32'hE1000000, 4'b1000, "ar_load_in_ready");
    #2;
    chk("ar_pre_out_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'h0);
    chk("ar_out_data", 32'(out_data), 32'h0);
    chk("ar_out_sel", 32'(out_sel), 32'h0);
    chk("ar_beat_cnt", 32'(beat_cnt), 32'h0);
    chk("ar_in_ready", 32'(in_ready), 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin at full throughput from rr_ptr=0
    for (int k = 0; k < 8; k++) begin
      vec_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'(1 << (k % 4)), "rr_in_ready");
      chk("rr_out_valid", 32'(out_valid), 32'h1);
    end
    vec_cycle(1'b1, 2'd0, 4'b0000, 1'b1, 32'h0, 4'b0000, "rr_drain_in_ready");
    chk("rr_beat_cnt", 32'(beat_cnt), 32'd8);

    // Eight more beats take the 4-bit counter from 8 through 15 to 0
    for (int k = 0; k < 8; k++)
      vec_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'(1 << (k % 4)), "wrap_in_ready");
    vec_cycle(1'b1, 2'd0, 4'b0000, 1'b1, 32'h0, 4'b0000, "wrap_drain_in_ready");
    chk("wrap_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
